dmem_responder: RTL and testbench

- Data-side memory responder for the single-cycle RV32 core: the target end of the core's data port (MemWrite / address / WriteData / ReadData).
- Word-addressed RAM plus a small memory-mapped peripheral window: free-running cycle counter, compare timer with interrupt flag, 8-bit GPIO output register.
- Reads are combinational, as the single-cycle core requires. All state updates happen on the rising clk edge.

---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM plus MMIO window (CYCLE, TIMER_CMP, STATUS, GPIO).
// Define DMEM_BUSERR_EN to add the sticky bus_err flag and STATUS bit1 BUSERR.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic        irq
`ifdef DMEM_BUSERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  localparam logic [1:0] OFF_CYCLE  = 2'd0;
  localparam logic [1:0] OFF_CMP    = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_GPIO   = 2'd3;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] cycle_cnt;
  logic [31:0] timer_cmp;
  logic        match;
  logic [7:0]  gpio;
  logic        buserr;

  logic          ram_hit;
  logic          mmio_sel;
  logic          unmapped;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_off;
  logic          wr_ram;
  logic          wr_mmio;
  logic [31:0]   status_rd;
  logic [31:0]   mmio_rd;

  // RAM takes priority should the window ever be placed inside the RAM range
  assign ram_hit  = (ALUResult < RAM_BYTES);
  assign mmio_sel = (ALUResult[31:4] == MMIO_BASE[31:4]) && !ram_hit;
  assign unmapped = !ram_hit && !mmio_sel;
  assign ram_idx  = ALUResult[AW+1:2];
  assign reg_off  = ALUResult[3:2];
  assign wr_ram   = MemWrite && ram_hit;
  assign wr_mmio  = MemWrite && mmio_sel;

`ifdef DMEM_BUSERR_EN
  assign status_rd = {30'd0, buserr, match};
  assign bus_err   = buserr;
`else
  assign status_rd = {31'd0, match};
`endif

  always_comb begin
    mmio_rd = 32'd0;
    case (reg_off)
      OFF_CYCLE:  mmio_rd = cycle_cnt;
      OFF_CMP:    mmio_rd = timer_cmp;
      OFF_STATUS: mmio_rd = status_rd;
      OFF_GPIO:   mmio_rd = {24'd0, gpio};
      default:    mmio_rd = 32'd0;
    endcase
  end

  always_comb begin
    ReadData = 32'd0;
    if (ram_hit)
      ReadData = mem[ram_idx];
    else if (mmio_sel)
      ReadData = mmio_rd;
  end

  // RAM has no reset, but a store coinciding with reset is still dropped
  always_ff @(posedge clk) begin
    if (reset && wr_ram)
      mem[ram_idx] <= WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= 32'd0;
      timer_cmp <= 32'hFFFF_FFFF;
      match     <= 1'b0;
      gpio      <= 8'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (wr_mmio && reg_off == OFF_CMP)
        timer_cmp <= WriteData;
      // compare uses pre-edge values; set beats W1C
      if (cycle_cnt == timer_cmp)
        match <= 1'b1;
      else if (wr_mmio && reg_off == OFF_STATUS && WriteData[0])
        match <= 1'b0;
      if (wr_mmio && reg_off == OFF_GPIO)
        gpio <= WriteData[7:0];
    end
  end

`ifdef DMEM_BUSERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      buserr <= 1'b0;
    else if (MemWrite && unmapped)
      buserr <= 1'b1;
    else if (wr_mmio && reg_off == OFF_STATUS && WriteData[1])
      buserr <= 1'b0;
  end
`else
  assign buserr = 1'b0;
`endif

  assign gpio_out = gpio;
  assign irq      = match;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, decode, CYCLE, timer match, GPIO, reset.
// Build with DMEM_BUSERR_EN defined to also cover the bus error flag.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic        irq;
`ifdef DMEM_BUSERR_EN
  logic        bus_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(64), .MMIO_BASE(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .gpio_out  (gpio_out),
`ifdef DMEM_BUSERR_EN
    .bus_err   (bus_err),
`endif
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    MemWrite  = 1'b0;
    ALUResult = a;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ALUResult = a;
    WriteData = d;
    MemWrite  = 1'b1;
    #1;
    tick();
    MemWrite  = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = 32'd0;
    WriteData = 32'd0;
    #2;
    chk("rst_gpio", {24'd0, gpio_out}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // counter after 10 edges, then ignored write, then GPIO
    repeat (10) tick();
    rd(MB);                 chk("cycle_10", ReadData, 32'd10);
    wr(MB, 32'h0000_1234);
    rd(MB);                 chk("cycle_ro", ReadData, 32'd11);
    wr(MB + 32'hC, 32'h0000_01A5);
    chk("gpio_out", {24'd0, gpio_out}, 32'h0000_00A5);
    rd(MB + 32'hC);         chk("gpio_rd", ReadData, 32'h0000_00A5);
    rd(MB + 32'h4);         chk("cmp_rst", ReadData, 32'hFFFF_FFFF);

    // RAM
    wr(32'h0, 32'h1234_5678);
    wr(32'h10, 32'h1111_1111);
    ALUResult = 32'h10;
    WriteData = 32'hDEAD_BEEF;
    MemWrite  = 1'b1;
    #1;
    chk("ram_rdw_old", ReadData, 32'h1111_1111);
    tick();
    MemWrite = 1'b0;
    rd(32'h10);             chk("ram_rd", ReadData, 32'hDEAD_BEEF);
    rd(32'h13);             chk("ram_lowbits", ReadData, 32'hDEAD_BEEF);
    wr(32'hFC, 32'hCAFE_F00D);
    rd(32'hFC);             chk("ram_top", ReadData, 32'hCAFE_F00D);
    rd(32'h100);            chk("unmap_ramend", ReadData, 32'h0);
    wr(32'h100, 32'hBAD0_BAD0);
    rd(32'h0);              chk("ram_noalias", ReadData, 32'h1234_5678);
    rd(32'h4000_0000);      chk("unmap_rd", ReadData, 32'h0);
    rd(MB + 32'h10);        chk("unmap_above", ReadData, 32'h0);
    rd(MB - 32'h4);         chk("unmap_below", ReadData, 32'h0);

`ifdef DMEM_BUSERR_EN
    chk("berr_set", {31'd0, bus_err}, 32'h1);
    rd(MB + 32'h8);         chk("berr_status", ReadData, 32'h2);
    wr(MB + 32'h8, 32'h2);
    chk("berr_clr", {31'd0, bus_err}, 32'h0);
    wr(32'h4000_0000, 32'h5);
    chk("berr_set2", {31'd0, bus_err}, 32'h1);
    wr(MB + 32'h8, 32'h1);
    chk("berr_bit0", {31'd0, bus_err}, 32'h1);
    wr(MB + 32'h8, 32'h2);
    rd(32'h4000_0000);
    tick();
    chk("berr_rd", {31'd0, bus_err}, 32'h0);
`else
    rd(MB + 32'h8);         chk("status_nobe", ReadData, 32'h0);
`endif

    // timer match, fresh count from reset
    tick();
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) tick();
    wr(MB + 32'h4, 32'h20);
    repeat (26) tick();
    chk("irq_pre", {31'd0, irq}, 32'h0);
    rd(MB);                 chk("cycle_20", ReadData, 32'h20);
    tick();
    chk("irq_rise", {31'd0, irq}, 32'h1);
    rd(MB + 32'h8);         chk("status_match", ReadData, 32'h1);
    wr(MB + 32'h8, 32'h1);
    chk("irq_w1c", {31'd0, irq}, 32'h0);
    wr(MB + 32'h4, 32'h22);
    chk("cmp_old", {31'd0, irq}, 32'h0);
    wr(MB + 32'h4, 32'h30);
    repeat (12) tick();
    wr(MB + 32'h8, 32'h1);
    chk("set_wins", {31'd0, irq}, 32'h1);

    // reset mid-run with a store in flight
    wr(MB + 32'hC, 32'hFF);
    chk("pre_rst_gpio", {24'd0, gpio_out}, 32'hFF);
    chk("pre_rst_irq", {31'd0, irq}, 32'h1);
    ALUResult = 32'h10;
    WriteData = 32'h0;
    MemWrite  = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_gpio", {24'd0, gpio_out}, 32'h0);
    chk("arst_irq", {31'd0, irq}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    reset    = 1'b1;
    rd(32'h10);             chk("ram_kept", ReadData, 32'hDEAD_BEEF);
    rd(MB + 32'h4);         chk("cmp_rst2", ReadData, 32'hFFFF_FFFF);
    rd(MB);                 chk("cycle_rst", ReadData, 32'h0);

    // wrap of CYCLE; reset TIMER_CMP also matches at 0xFFFF_FFFF
    tick();
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    rd(MB);                 chk("cycle_pre", ReadData, 32'hFFFF_FFFF);
    tick();
    rd(MB);                 chk("cycle_wrap", ReadData, 32'h0);
    chk("irq_wrap", {31'd0, irq}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
